// File: rtl/bram_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : bram_wr_arbiter
// Purpose  : Round-robin burst arbiter that shares the port A write side of
//            the dual-clock block memory between two burst writers. It
//            generates sequential burst addresses and registers the memory
//            strobes, so a beat accepted in cycle t is written in cycle t+1.
// Ports    : clk_30mhz, reset        - write-domain clock, sync active-high reset
//            locked                  - clock lock; low halts and flushes to idle
//            reqN_valid/addr/data/last, reqN_ready
//                                    - burst writer N (valid/ready handshake,
//                                      addr sampled on first beat only)
//            bram_en/we/addr/din     - registered port A strobes
//            grant, busy             - one-hot current owner, owner present
// Revision : 1.0 - initial release
// ============================================================================
module bram_wr_arbiter #(
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 16
) (
  input  logic              clk_30mhz,
  input  logic              reset,
  input  logic              locked,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req0_last,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  input  logic              req1_last,
  output logic              req1_ready,
  output logic              bram_en,
  output logic              bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_din,
  output logic [1:0]        grant,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_OWN0 = 2'd1,
    S_OWN1 = 2'd2
  } state_t;

  // Beat counter wide enough for MAX_BURST up to 256.
  localparam logic [8:0] C_CNT_LAST = 9'(MAX_BURST - 1);

  state_t              state_q, state_d;
  logic                rr_last_q, rr_last_d;
  logic [8:0]          beat_cnt_q, beat_cnt_d;
  logic                en_q, en_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   din_q, din_d;

  logic                w_acc;
  logic                w_own_last;
  logic [ADDR_W-1:0]   w_own_addr;
  logic [DATA_W-1:0]   w_own_data;

  // Ready is purely a function of ownership and lock so a lock loss stops
  // acceptance in the same cycle it is seen.
  assign req0_ready = locked && (state_q == S_OWN0);
  assign req1_ready = locked && (state_q == S_OWN1);

  assign w_acc      = (req0_valid && req0_ready) || (req1_valid && req1_ready);
  assign w_own_last = (state_q == S_OWN1) ? req1_last : req0_last;
  assign w_own_addr = (state_q == S_OWN1) ? req1_addr : req0_addr;
  assign w_own_data = (state_q == S_OWN1) ? req1_data : req0_data;

  always_comb begin
    state_d    = state_q;
    rr_last_d  = rr_last_q;
    beat_cnt_d = beat_cnt_q;
    en_d       = 1'b0;
    addr_d     = addr_q;
    din_d      = din_q;

    case (state_q)
      S_IDLE: begin
        beat_cnt_d = '0;
        // On a tie the requester that did not own last wins.
        if (req0_valid && (!req1_valid || rr_last_q)) begin
          state_d = S_OWN0;
        end else if (req1_valid) begin
          state_d = S_OWN1;
        end
      end
      S_OWN0, S_OWN1: begin
        if (w_acc) begin
          en_d   = 1'b1;
          din_d  = w_own_data;
          // First beat of a grant takes the requester's address; later beats
          // step from the last written address, wrapping at the top.
          addr_d = (beat_cnt_q == '0) ? w_own_addr
                                      : addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
          if (w_own_last || (beat_cnt_q == C_CNT_LAST)) begin
            state_d    = S_IDLE;
            rr_last_d  = (state_q == S_OWN1);
            beat_cnt_d = '0;
          end else begin
            beat_cnt_d = beat_cnt_q + 9'd1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // A beat registered before lock loss is still written, because the flush
  // only takes effect at the edge where locked is sampled low.
  always_ff @(posedge clk_30mhz) begin
    if (reset || !locked) begin
      state_q    <= S_IDLE;
      rr_last_q  <= 1'b1;
      beat_cnt_q <= '0;
      en_q       <= 1'b0;
      addr_q     <= '0;
      din_q      <= '0;
    end else begin
      state_q    <= state_d;
      rr_last_q  <= rr_last_d;
      beat_cnt_q <= beat_cnt_d;
      en_q       <= en_d;
      addr_q     <= addr_d;
      din_q      <= din_d;
    end
  end

  assign bram_en   = en_q;
  assign bram_we   = en_q;
  assign bram_addr = addr_q;
  assign bram_din  = din_q;
  assign grant     = {state_q == S_OWN1, state_q == S_OWN0};
  assign busy      = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_bram_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_bram_wr_arbiter
// Purpose  : Directed bench for bram_wr_arbiter. Expected memory writes are a
//            hand-built table compared in order against every observed write;
//            per-beat and multi-cycle checks cover latency, grant, wrap,
//            forced release, lock loss and bubbles.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bram_wr_arbiter;

  logic        clk_30mhz = 1'b0;
  logic        reset = 1'b1;
  logic        locked = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic [9:0]  req0_addr = '0, req1_addr = '0;
  logic [31:0] req0_data = '0, req1_data = '0;
  logic        req0_last = 1'b0, req1_last = 1'b0;
  logic        req0_ready, req1_ready;
  logic        bram_en, bram_we;
  logic [9:0]  bram_addr;
  logic [31:0] bram_din;
  logic [1:0]  grant;
  logic        busy;

  bram_wr_arbiter #(.ADDR_W(10), .DATA_W(32), .MAX_BURST(16)) dut (
    .clk_30mhz (clk_30mhz),
    .reset     (reset),
    .locked    (locked),
    .req0_valid(req0_valid),
    .req0_addr (req0_addr),
    .req0_data (req0_data),
    .req0_last (req0_last),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid),
    .req1_addr (req1_addr),
    .req1_data (req1_data),
    .req1_last (req1_last),
    .req1_ready(req1_ready),
    .bram_en   (bram_en),
    .bram_we   (bram_we),
    .bram_addr (bram_addr),
    .bram_din  (bram_din),
    .grant     (grant),
    .busy      (busy)
  );

  always #17 clk_30mhz = ~clk_30mhz;

  int errs   = 0;
  int checks = 0;
  int cyc    = 0;

  always @(posedge clk_30mhz) cyc <= cyc + 1;

  typedef struct {
    logic [9:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_tab[64];
  int          n_exp = 0;
  logic [41:0] wq[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic [9:0] a, input logic [31:0] d);
    exp_tab[n_exp].addr = a;
    exp_tab[n_exp].data = d;
    n_exp++;
  endtask

  // Record every memory write as it is presented.
  always @(negedge clk_30mhz) begin
    if (bram_en || bram_we) begin
      chk("en_eq_we", {63'd0, bram_we}, {63'd0, bram_en});
      if (bram_en) wq.push_back({bram_addr, bram_din});
    end
  end

  task automatic drive(input int r, input bit v, input logic [9:0] a,
                       input logic [31:0] d, input bit l);
    if (r == 0) begin
      req0_valid = v; req0_addr = a; req0_data = d; req0_last = l;
    end else begin
      req1_valid = v; req1_addr = a; req1_data = d; req1_last = l;
    end
  endtask

  task automatic wait_accept(input int r, output bit ok);
    bit acc;
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk_30mhz);
      acc = (r == 0) ? (req0_valid && req0_ready) : (req1_valid && req1_ready);
      @(posedge clk_30mhz); #1;
      if (acc) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errs++;
      $display("FAIL accept_timeout: requester %0d got no accept, required one within 200 cycles", r);
    end
  endtask

  // Burst of n beats, data d0+2*i, start address held on addr for all beats.
  // gap_at >= 0 drops valid for 3 cycles before that beat index.
  task automatic burst(input int r, input logic [9:0] a, input int n, input bit lst,
                       input logic [31:0] d0, input int gap_at,
                       output int first_cyc, output int last_cyc);
    bit ok;
    bit rel;
    logic [1:0] own;
    own = (r == 0) ? 2'b01 : 2'b10;
    first_cyc = -1;
    last_cyc  = -1;
    for (int i = 0; i < n; i++) begin
      if (i == gap_at) begin
        drive(r, 1'b0, a, d0 + 32'(2 * i), 1'b0);
        for (int g = 0; g < 3; g++) begin
          chk("gap_grant", {62'd0, grant}, {62'd0, own});
          if (g > 0) chk("gap_no_we", {63'd0, bram_we}, 64'd0);
          @(posedge clk_30mhz); #1;
        end
      end
      drive(r, 1'b1, a, d0 + 32'(2 * i), lst && (i == n - 1));
      wait_accept(r, ok);
      if (!ok) begin
        drive(r, 1'b0, a, '0, 1'b0);
        return;
      end
      if (i == 0) first_cyc = cyc;
      last_cyc = cyc;
      rel = (lst && (i == n - 1)) || (i == 15);
      chk("wr_latency_we", {63'd0, bram_we}, 64'd1);
      chk("wr_latency_din", {32'd0, bram_din}, {32'd0, d0 + 32'(2 * i)});
      chk("grant_after_beat", {62'd0, grant}, rel ? 64'd0 : {62'd0, own});
    end
    drive(r, 1'b0, a, '0, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk_30mhz);
    #1;
    reset = 1'b0;
  endtask

  int f0, l0, f1, l1, f0b, l0b;
  bit ok;

  initial begin
    // Expected write stream, in order.
    add(10'h010, 32'h0); add(10'h011, 32'h2); add(10'h012, 32'h4); add(10'h013, 32'h6);
    add(10'h100, 32'h1000); add(10'h101, 32'h1002);
    add(10'h200, 32'h2000); add(10'h201, 32'h2002);
    add(10'h110, 32'h1100); add(10'h111, 32'h1102);
    add(10'h210, 32'h2100); add(10'h211, 32'h2102);
    add(10'h3FE, 32'h3000); add(10'h3FF, 32'h3002); add(10'h000, 32'h3004); add(10'h001, 32'h3006);
    for (int i = 0; i < 16; i++) add(10'h020 + 10'(i), 32'h4000 + 32'(2 * i));
    add(10'h300, 32'h5000); add(10'h301, 32'h5002);
    add(10'h030, 32'h4020); add(10'h031, 32'h4022); add(10'h032, 32'h4024); add(10'h033, 32'h4026);
    add(10'h040, 32'h6000); add(10'h041, 32'h6002);
    add(10'h050, 32'h7000); add(10'h350, 32'h8000);
    for (int i = 0; i < 5; i++) add(10'h060 + 10'(i), 32'h9000 + 32'(2 * i));

    // Reset state, sampled while reset is still asserted.
    reset = 1'b1;
    repeat (3) @(posedge clk_30mhz);
    #1;
    chk("rst_grant", {62'd0, grant}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_ready0", {63'd0, req0_ready}, 64'd0);
    chk("rst_ready1", {63'd0, req1_ready}, 64'd0);
    chk("rst_en", {63'd0, bram_en}, 64'd0);
    chk("rst_addr", {54'd0, bram_addr}, 64'd0);
    chk("rst_din", {32'd0, bram_din}, 64'd0);
    reset = 1'b0;
    @(posedge clk_30mhz); #1;

    // Single burst of 4 from requester 0.
    burst(0, 10'h010, 4, 1'b1, 32'h0, -1, f0, l0);
    chk("s1_busy_after", {63'd0, busy}, 64'd0);

    // Simultaneous requests after reset: order 0,1,0,1 with one dead cycle.
    do_reset();
    fork
      burst(0, 10'h100, 2, 1'b1, 32'h1000, -1, f0, l0);
      burst(1, 10'h200, 2, 1'b1, 32'h2000, -1, f1, l1);
    join
    chk("s2_dead_cycle", 64'(f1 - l0), 64'd2);
    fork
      burst(0, 10'h110, 2, 1'b1, 32'h1100, -1, f0, l0);
      burst(1, 10'h210, 2, 1'b1, 32'h2100, -1, f1, l1);
    join
    chk("s2_round2_order", 64'(f1 - l0), 64'd2);

    // Address wrap at the top of memory.
    burst(1, 10'h3FE, 4, 1'b1, 32'h3000, -1, f1, l1);

    // Forced release after 16 beats, pending requester 1 goes next.
    fork
      begin
        burst(0, 10'h020, 16, 1'b0, 32'h4000, -1, f0, l0);
        burst(0, 10'h030, 4, 1'b1, 32'h4020, -1, f0b, l0b);
      end
      begin
        repeat (3) @(posedge clk_30mhz);
        #1;
        burst(1, 10'h300, 2, 1'b1, 32'h5000, -1, f1, l1);
      end
    join
    chk("s4_req1_after_forced", 64'(f1 - l0), 64'd2);
    chk("s4_req0_resume", 64'(f0b - l1), 64'd2);

    // Lock loss after beat 2 of 6.
    drive(0, 1'b1, 10'h040, 32'h6000, 1'b0);
    wait_accept(0, ok);
    req0_data = 32'h6002;
    wait_accept(0, ok);
    locked = 1'b0;
    req0_data = 32'h6004;
    #1;
    chk("lock_ready0_low", {63'd0, req0_ready}, 64'd0);
    chk("lock_beat2_we", {63'd0, bram_we}, 64'd1);
    chk("lock_beat2_addr", {54'd0, bram_addr}, 64'h041);
    @(posedge clk_30mhz); #1;
    chk("lock_grant", {62'd0, grant}, 64'd0);
    chk("lock_we", {63'd0, bram_we}, 64'd0);
    chk("lock_addr", {54'd0, bram_addr}, 64'd0);
    req0_valid = 1'b0;
    @(posedge clk_30mhz); #1;
    locked = 1'b1;
    fork
      burst(0, 10'h050, 1, 1'b1, 32'h7000, -1, f0, l0);
      burst(1, 10'h350, 1, 1'b1, 32'h8000, -1, f1, l1);
    join
    chk("lock_rr_restart", 64'(f1 - l0), 64'd2);

    // Bubble of 3 cycles mid-burst.
    burst(0, 10'h060, 5, 1'b1, 32'h9000, 2, f0, l0);

    repeat (3) @(posedge clk_30mhz);
    #1;

    chk("write_count", 64'(wq.size()), 64'(n_exp));
    for (int i = 0; i < n_exp; i++) begin
      if (i < wq.size()) begin
        chk($sformatf("wr%0d_addr", i), {54'd0, wq[i][41:32]}, {54'd0, exp_tab[i].addr});
        chk($sformatf("wr%0d_data", i), {32'd0, wq[i][31:0]}, {32'd0, exp_tab[i].data});
      end
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d", errs);
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/bram_wr_arbiter.md
Name: bram_wr_arbiter

Overview:
Shares the single write port (port A, clk_30mhz domain) of the dual-clock 1024x32 block memory between two burst writers. Typical writers are the address-ramp pattern generator (requester 0) and a capture/host path (requester 1). The block does round-robin burst arbitration, generates sequential addresses and registers the memory-side strobes. The 100 MHz read side is not touched by this block.

Parameters:
ADDR_W, 10, memory address width (depth 2^ADDR_W)
DATA_W, 32, write data width
MAX_BURST, 16, maximum beats per grant before forced release (range 1..256)

Ports:
clk_30mhz  in  1  write-domain clock
reset  in  1  synchronous, active-high reset
locked  in  1  clock-wizard lock; low = halt and flush to IDLE
req0_valid  in  1  requester 0 beat valid
req0_addr  in  ADDR_W  requester 0 burst start address (sampled on first beat only)
req0_data  in  DATA_W  requester 0 write data
req0_last  in  1  requester 0 final beat of burst
req0_ready  out  1  requester 0 beat accepted when valid&ready
req1_valid, req1_addr, req1_data, req1_last, req1_ready: same as requester 0
bram_en  out  1  port A enable
bram_we  out  1  port A write enable
bram_addr  out  ADDR_W  port A address
bram_din  out  DATA_W  port A write data
grant  out  2  one-hot current owner (00 = none)
busy  out  1  grant != 00

Behaviour:
- Reset / locked low: FSM -> IDLE, grant=00, readies=0, bram_en=bram_we=0, bram_addr=0, bram_din=0, beat_cnt=0, rr_last=1 (so requester 0 wins the first tie). locked low mid-burst aborts the burst. Beats already registered still complete their write that cycle. Nothing is replayed.
- FSM states: IDLE, OWN0, OWN1.
- IDLE:
  - Only req0_valid: -> OWN0.
  - Only req1_valid: -> OWN1.
  - Both valid: grant goes to the requester that is not rr_last.
  - Arbitration takes 1 cycle; the first beat can be accepted in the cycle after the IDLE decision.
- OWNn:
  - reqn_ready = 1 (combinational from state & locked); the other requester's ready = 0.
  - Beat accepted = reqn_valid & reqn_ready.
  - First accepted beat uses reqn_addr. Later beats use the internal pointer + 1, wrapping 2^ADDR_W-1 -> 0.
- Memory strobe latency 1: an accept in cycle t gives bram_en=bram_we=1, with bram_addr and bram_din set to the beat, in cycle t+1. With no accept, bram_en=bram_we=0 and bram_addr/bram_din hold their values.
- beat_cnt increments per accepted beat and clears on release.
- Release happens on the accepted beat if reqn_last=1 or beat_cnt reaches MAX_BURST-1. On release: rr_last=n, state -> IDLE.
  - Back-to-back reuse needs the IDLE cycle, so there is 1 dead cycle between grants.
- Forced release (MAX_BURST) without last: the requester keeps its burst context on its own side. Its next grant re-samples reqn_addr, so the requester must present its continuation address.
- A valid with no grant is stalled with no data loss. The requester holds valid, addr, data and last stable until accepted.
- grant changes only on IDLE entry or exit. A bubble beat (valid low while owning) keeps the grant; there is no timeout.

Test Plan:
- Reset then req0 burst of 4 at addr 0x010, data 0,2,4,6, last on beat 4 -> bram_we pulses at addr 0x010..0x013 with those data, 1 cycle after each accept; grant=01 then 00.
- req0 and req1 valid in the same cycle after reset -> req0 served first. Then 1 IDLE cycle, then req1. Repeat both -> order 0,1,0,1.
- req1 burst start 0x3FE, 4 beats -> addresses 0x3FE, 0x3FF, 0x000, 0x001 (wrap).
- req0 burst of 20 with no last before beat 20, MAX_BURST=16 -> release after 16 beats. Pending req1 granted next. req0 resumes with its re-presented address.
- locked dropped after beat 2 of 6 -> next cycle grant=00, readies=0, only beats 1–2 written. After locked returns, arbitration restarts from rr_last=1.
- req0_valid toggled low for 3 cycles mid-burst -> grant held, no bram_we during the gap, addresses continue contiguously.
